// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the hazard controller and the
//                MIPS decoder (cause encoding, zero register, opcodes/functs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_MEMWAIT  = 2'd1,
        HZ_REDIRECT = 2'd2,
        HZ_LOADUSE  = 2'd3
    } hazard_cause_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// ============================================================================
//  Module      : hazard_perf_cnt
//  Description : Saturating event counter, cleared by synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Prioritised stall/flush control for the five-stage MIPS
//                pipeline with configurable load-use latency. Performance
//                counters are built only when HAZARD_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_redirect,
    input  logic                  mem_wait,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            hazard_cause,
    output logic [CNT_W-1:0]      perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_flush_events
);

    localparam int LU_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_LAT - 1);

    logic [LU_W-1:0] cnt_d;
    logic [LU_W-1:0] cnt_q;
    logic            w_detect;
    logic            w_lu_stall;
    hazard_cause_e   w_cause;

    assign w_detect = ex_mem_to_reg
                    && (ex_dst != REG_ADDR_W'(REG_ZERO))
                    && ((id_uses_rs && (id_rs == ex_dst))
                     || (id_uses_rt && (id_rt == ex_dst)));

    assign w_lu_stall = w_detect || (cnt_q != '0);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        w_cause = HZ_NONE;
        cnt_d   = cnt_q;
        if (reset) begin
            cnt_d = '0;
        end else if (mem_wait) begin
            // Freeze everything; the pending load-use count is preserved.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            w_cause = HZ_MEMWAIT;
        end else if (ex_redirect) begin
            // The ID instruction is wrong-path, so any pending stall is dropped.
            flush_d = 1'b1;
            flush_e = 1'b1;
            w_cause = HZ_REDIRECT;
            cnt_d   = '0;
        end else if (w_lu_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            w_cause = HZ_LOADUSE;
            if (w_detect && (cnt_q == '0)) begin
                cnt_d = LU_RELOAD;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hazard_cause = w_cause;

`ifdef HAZARD_PERF_CNT_EN
    logic w_any_stall;
    assign w_any_stall = stall_f | stall_d | stall_e | stall_m;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_any_stall),
        .o_count (perf_stall_cycles)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (flush_d),
        .o_count (perf_flush_events)
    );
`else
    assign perf_stall_cycles = '0;
    assign perf_flush_events = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench driving LOAD_LAT=3 and LOAD_LAT=1 instances
//                with shared directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_uses_rs, id_uses_rt, ex_mem_to_reg, ex_redirect, mem_wait;

    logic        sf3, sd3, se3, sm3, fd3, fe3, sf1, sd1, se1, sm1, fd1, fe1;
    logic [1:0]  hc3, hc1;
    logic [31:0] ps3, pf3, ps1, pf1;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(32)) u_dut3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_dst(ex_dst),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_redirect(ex_redirect), .mem_wait(mem_wait),
        .stall_f(sf3), .stall_d(sd3), .stall_e(se3), .stall_m(sm3),
        .flush_d(fd3), .flush_e(fe3), .hazard_cause(hc3),
        .perf_stall_cycles(ps3), .perf_flush_events(pf3)
    );

    hazard_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_dst(ex_dst),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_redirect(ex_redirect), .mem_wait(mem_wait),
        .stall_f(sf1), .stall_d(sd1), .stall_e(se1), .stall_m(sm1),
        .flush_d(fd1), .flush_e(fe1), .hazard_cause(hc1),
        .perf_stall_cycles(ps1), .perf_flush_events(pf1)
    );

    // Output word: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, cause}
    logic [7:0] w_out3, w_out1;
    assign w_out3 = {sf3, sd3, se3, sm3, fd3, fe3, hc3};
    assign w_out1 = {sf1, sd1, se1, sm1, fd1, fe1, hc1};

    typedef struct {
        int         vec;
        logic [7:0] e3;
        logic [7:0] e1;
        logic       chk;
        int         ps3;
        int         pf3;
        int         ps1;
        int         pf1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_no   = 0;

    function automatic logic [31:0] pexp(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic cmp(input string name, input int vec, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, vec, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so each vector is sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("out_lat3", e.vec, 32'(w_out3), 32'(e.e3));
            cmp("out_lat1", e.vec, 32'(w_out1), 32'(e.e1));
            if (e.chk) begin
                cmp("perf_stall_lat3", e.vec, ps3, pexp(e.ps3));
                cmp("perf_flush_lat3", e.vec, pf3, pexp(e.pf3));
                cmp("perf_stall_lat1", e.vec, ps1, pexp(e.ps1));
                cmp("perf_flush_lat1", e.vec, pf1, pexp(e.pf1));
            end
        end
    end

    task automatic step(input logic rst_i, input logic [4:0] rs_i, input logic [4:0] rt_i,
                        input logic urs_i, input logic urt_i, input logic [4:0] dst_i,
                        input logic m2r_i, input logic red_i, input logic mw_i,
                        input logic [7:0] e3, input logic [7:0] e1,
                        input logic chk = 1'b0, input int eps3 = 0, input int epf3 = 0,
                        input int eps1 = 0, input int epf1 = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst_i;
        id_rs         = rs_i;
        id_rt         = rt_i;
        id_uses_rs    = urs_i;
        id_uses_rt    = urt_i;
        ex_dst        = dst_i;
        ex_mem_to_reg = m2r_i;
        ex_redirect   = red_i;
        mem_wait      = mw_i;
        e.vec = vec_no;
        e.e3  = e3;
        e.e1  = e1;
        e.chk = chk;
        e.ps3 = eps3;
        e.pf3 = epf3;
        e.ps1 = eps1;
        e.pf1 = epf1;
        exp_q.push_back(e);
        vec_no++;
    endtask

    localparam logic [7:0] NONE = 8'h00;
    localparam logic [7:0] LU   = 8'hC7;
    localparam logic [7:0] MW   = 8'hF1;
    localparam logic [7:0] RD   = 8'h0E;

    initial begin
        reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_dst = '0; ex_mem_to_reg = 1'b0; ex_redirect = 1'b0; mem_wait = 1'b0;

        // Reset overrides a live hazard, then counters read zero.
        step(1, 5, 0, 1, 0, 5, 1, 0, 0, NONE, NONE);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE, 1, 0, 0, 0, 0);
        // Load-use on rs, EX bubbled afterwards.
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, LU,   LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, LU,   NONE);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, LU,   NONE);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE);
        // One redirect, then counter readback.
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, RD,   RD);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE, 1, 3, 1, 1, 1);
        // Register zero and unused rt never stall.
        step(0, 0, 0, 1, 1, 0, 1, 0, 0, NONE, NONE);
        step(0, 3, 5, 1, 0, 5, 1, 0, 0, NONE, NONE);
        // Load-use on rt, redirect in the second stall cycle clears the count.
        step(0, 7, 7, 0, 1, 7, 1, 0, 0, LU,   LU);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, RD,   RD);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE);
        // Two mem_wait cycles inside the stall extend it to five cycles.
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, LU,   LU);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, MW,   MW);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, MW,   MW);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, LU,   NONE);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, LU,   NONE);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE);
        // Simultaneous detect and mem_wait: no load, detect re-evaluated later.
        step(0, 5, 0, 1, 0, 5, 1, 0, 1, MW,   MW);
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, LU,   LU);
        // Reset mid-stall drops the pending count and clears the counters.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE, 1, 0, 0, 0, 0);
        // Priority: redirect over load-use, mem_wait over redirect.
        step(0, 5, 0, 1, 0, 5, 1, 1, 0, RD,   RD);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, MW,   MW);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
